// File: rtl/dp_ram_arb_pkg.sv
// Shared defaults, index type and the per-port response tag for the dual-port RAM arbiter.
// Pure declarations: no latency, no flow control.
package dp_ram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam int DEF_NUM_REQ    = 4;
    localparam int IDX_W          = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic active;
        logic is_read;
        idx_t idx;
    } rsp_tag_t;

    // Successor of i in a ring of n requesters.
    function automatic idx_t wrap_inc(idx_t i, int n);
        return (int'(i) == n - 1) ? '0 : idx_t'(int'(i) + 1);
    endfunction

endpackage

// File: rtl/dp_ram_arb_rr_pick.sv
// Rotating-priority finder: first set bit of mask searching upward from start, wrapping.
// Purely combinational; no backpressure.
module rr_pick
    import dp_ram_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0] mask,
    input  idx_t         start,
    output logic         found,
    output idx_t         idx
);

    function automatic idx_t rot(idx_t s, int k);
        int j;
        j = int'(s) + k;
        if (j >= N) begin
            j = j - N;
        end
        return idx_t'(j);
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && mask[i] && (rot(start, k) == idx_t'(i))) begin
                    found = 1'b1;
                    idx   = idx_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/dp_ram_arb.sv
// Round-robin arbiter mapping up to two of NUM_REQ requesters onto a dual-port RAM per cycle.
// Grant is combinational (req_ready); read data returns one cycle later; ungranted requests simply wait.
module dp_ram_arb
    import dp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
    output logic                           wea,
    output logic                           web,
    output logic                           rea,
    output logic                           reb,
    output logic [ADDR_WIDTH-1:0]          addra,
    output logic [ADDR_WIDTH-1:0]          addrb,
    output logic [DATA_WIDTH-1:0]          dina,
    output logic [DATA_WIDTH-1:0]          dinb,
    input  logic [DATA_WIDTH-1:0]          douta,
    input  logic [DATA_WIDTH-1:0]          doutb
);

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    idx_t                  rr_ptr;
    rsp_tag_t              tag_a;
    rsp_tag_t              tag_b;

    logic [NUM_REQ-1:0]    mask_a;
    logic [NUM_REQ-1:0]    mask_b;
    logic                  a_found;
    logic                  b_found;
    idx_t                  a_idx;
    idx_t                  b_idx;
    logic                  a_we;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] b_wdata;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Holding the mask at zero in reset keeps grants and RAM ports idle.
    assign mask_a = rst ? '0 : req_valid;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .mask  (mask_a),
        .start (rr_ptr),
        .found (a_found),
        .idx   (a_idx)
    );

    always_comb begin
        a_we    = 1'b0;
        a_addr  = '0;
        a_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (a_idx == idx_t'(i)) begin
                a_we    = req_we[i];
                a_addr  = addr_arr[i];
                a_wdata = wdata_arr[i];
            end
        end
    end

    // Port B skips the A winner and anything touching A's address where a write is involved.
    always_comb begin
        mask_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask_b[i] = mask_a[i] && (a_idx != idx_t'(i)) &&
                        !((addr_arr[i] == a_addr) && (req_we[i] || a_we));
        end
    end

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .mask  (mask_b),
        .start (rr_ptr),
        .found (b_found),
        .idx   (b_idx)
    );

    always_comb begin
        b_we    = 1'b0;
        b_addr  = '0;
        b_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (b_idx == idx_t'(i)) begin
                b_we    = req_we[i];
                b_addr  = addr_arr[i];
                b_wdata = wdata_arr[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (a_found && (a_idx == idx_t'(i))) ||
                           (b_found && (b_idx == idx_t'(i)));
        end
    end

    always_comb begin
        wea   = 1'b1;
        rea   = 1'b0;
        addra = '0;
        dina  = '0;
        if (a_found) begin
            wea   = ~a_we;
            rea   = ~a_we;
            addra = a_addr;
            dina  = a_we ? a_wdata : '0;
        end
    end

    always_comb begin
        web   = 1'b1;
        reb   = 1'b0;
        addrb = '0;
        dinb  = '0;
        if (b_found) begin
            web   = ~b_we;
            reb   = ~b_we;
            addrb = b_addr;
            dinb  = b_we ? b_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            tag_a  <= '0;
            tag_b  <= '0;
        end else begin
            tag_a  <= '{active: a_found, is_read: a_found && !a_we, idx: a_idx};
            tag_b  <= '{active: b_found, is_read: b_found && !b_we, idx: b_idx};
            if (b_found) begin
                rr_ptr <= wrap_inc(b_idx, NUM_REQ);
            end else if (a_found) begin
                rr_ptr <= wrap_inc(a_idx, NUM_REQ);
            end
        end
    end

    // Gating with rst drops a read whose data would land in the first reset cycle.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && tag_a.active && tag_a.is_read && (tag_a.idx == idx_t'(i))) begin
                rsp_valid[i]                          = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = douta;
            end
            if (!rst && tag_b.active && tag_b.is_read && (tag_b.idx == idx_t'(i))) begin
                rsp_valid[i]                          = 1'b1;
                rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = doutb;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_arb.sv
// Bench for dp_ram_arb: directed vector table, fairness run and random traffic against a queue-based model.
module tb_dp_ram_arb;

    localparam int DW = 2;
    localparam int AW = 2;
    localparam int N  = 4;
    localparam int MD = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_rdata;
    logic            wea, web, rea, reb;
    logic [AW-1:0]   addra, addrb;
    logic [DW-1:0]   dina, dinb;
    logic [DW-1:0]   douta = '0;
    logic [DW-1:0]   doutb = '0;

    dp_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wea(wea), .web(web), .rea(rea), .reb(reb),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(douta), .doutb(doutb)
    );

    // RAM attached to the arbiter: active-low write, registered read.
    logic [DW-1:0] ram [MD];
    always @(posedge clk) begin
        if (!wea) ram[addra] <= dina;
        if (!web) ram[addrb] <= dinb;
        if (rea)  douta <= ram[addra];
        if (reb)  doutb <= ram[addrb];
    end

    int m_ptr;
    int m_mem [MD];
    int g_a, g_b;
    bit pend_v [N];
    int pend_d [N];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic            r;
        logic [N-1:0]    v;
        logic [N-1:0]    we;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        logic [N-1:0]    erdy;
        logic [N-1:0]    erv;
        logic [N*DW-1:0] erd;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int f_addr(input int i);
        return int'(req_addr[i*AW +: AW]);
    endfunction

    function automatic int f_wdata(input int i);
        return int'(req_wdata[i*DW +: DW]);
    endfunction

    // Requesters eligible in rotation order from the pointer; A takes the first, B the first later non-conflicting one.
    task automatic model_grant(output int a, output int b);
        int elig[$];
        a = -1;
        b = -1;
        if (rst) return;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) elig.push_back(i);
        end
        if (elig.size() == 0) return;
        a = elig[0];
        for (int k = 1; k < elig.size(); k++) begin
            int j;
            j = elig[k];
            if (b < 0 && !(f_addr(j) == f_addr(a) && (req_we[j] || req_we[a]))) b = j;
        end
    endtask

    task automatic check_port(input string nm, input int g, input logic we, input logic re,
                              input logic [AW-1:0] ad, input logic [DW-1:0] din);
        logic          ewe, ere;
        logic [AW-1:0] ead;
        logic [DW-1:0] edin;
        ewe = 1'b1; ere = 1'b0; ead = '0; edin = '0;
        if (g >= 0) begin
            ewe  = !req_we[g];
            ere  = !req_we[g];
            ead  = AW'(f_addr(g));
            edin = req_we[g] ? DW'(f_wdata(g)) : '0;
        end
        chk(nm, {26'd0, we, re, ad, din}, {26'd0, ewe, ere, ead, edin});
    endtask

    task automatic model_check(input string tag);
        logic [N-1:0]    erdy, erv;
        logic [N*DW-1:0] erd;
        model_grant(g_a, g_b);
        erdy = '0;
        if (g_a >= 0) erdy[g_a] = 1'b1;
        if (g_b >= 0) erdy[g_b] = 1'b1;
        chk({tag, " ready"}, 32'(req_ready), 32'(erdy));
        check_port({tag, " portA"}, g_a, wea, rea, addra, dina);
        check_port({tag, " portB"}, g_b, web, reb, addrb, dinb);
        erv = '0;
        erd = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_v[i] && !rst) begin
                erv[i]         = 1'b1;
                erd[i*DW +: DW] = DW'(pend_d[i]);
            end
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(erv));
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(erd));
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        if (rst) begin
            m_ptr = 0;
            return;
        end
        if (g_a >= 0 && !req_we[g_a]) begin pend_v[g_a] = 1'b1; pend_d[g_a] = m_mem[f_addr(g_a)]; end
        if (g_b >= 0 && !req_we[g_b]) begin pend_v[g_b] = 1'b1; pend_d[g_b] = m_mem[f_addr(g_b)]; end
        if (g_a >= 0 && req_we[g_a]) m_mem[f_addr(g_a)] = f_wdata(g_a);
        if (g_b >= 0 && req_we[g_b]) m_mem[f_addr(g_b)] = f_wdata(g_b);
        if (g_b >= 0)      m_ptr = (g_b + 1) % N;
        else if (g_a >= 0) m_ptr = (g_a + 1) % N;
    endtask

    task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] we,
                         input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
        rst = r; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MD; i++) begin
            ram[i]   = DW'((i + 1) % 4);
            m_mem[i] = (i + 1) % 4;
        end
        for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_d[i] = 0; end
        m_ptr = 0;
        drive(1'b1, '0, '0, '0, '0);

        // r, valid, we, addr, wdata, exp ready, exp rsp_valid, exp rsp_rdata
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0010, 4'b0000, 8'h08, 8'h00, 4'b0010, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0010, 8'h0C});
        vecs.push_back('{1'b0, 4'b1000, 4'b0000, 8'hC0, 8'h00, 4'b1000, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 8'h00, 4'b0011, 4'b1000, 8'h00});
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 8'h00, 4'b1100, 4'b0011, 8'h09});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b1100, 8'h30});
        vecs.push_back('{1'b0, 4'b0111, 4'b0001, 8'h35, 8'h03, 4'b0101, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0010, 4'b0000, 8'h04, 8'h00, 4'b0010, 4'b0100, 8'h00});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0010, 8'h0C});
        vecs.push_back('{1'b0, 4'b0011, 4'b0000, 8'h00, 8'h00, 4'b0011, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0011, 8'h05});
        vecs.push_back('{1'b0, 4'b0100, 4'b0000, 8'h20, 8'h00, 4'b0100, 4'b0000, 8'h00});
        vecs.push_back('{1'b1, 4'b0100, 4'b0000, 8'h20, 8'h00, 4'b0000, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b1111, 4'b0000, 8'hE4, 8'h00, 4'b0011, 4'b0000, 8'h00});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 8'h00, 8'h00, 4'b0000, 4'b0011, 8'h0D});

        for (int n = 0; n < vecs.size(); n++) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            drive(vecs[n].r, vecs[n].v, vecs[n].we, vecs[n].a, vecs[n].d);
            @(negedge clk);
            model_check(tag);
            chk({tag, " tbl ready"}, 32'(req_ready), 32'(vecs[n].erdy));
            chk({tag, " tbl rsp_valid"}, 32'(rsp_valid), 32'(vecs[n].erv));
            chk({tag, " tbl rsp_rdata"}, 32'(rsp_rdata), 32'(vecs[n].erd));
            if (vecs[n].r) chk({tag, " reset wea/web/rea/reb"}, {28'd0, wea, web, rea, reb}, 32'b1100);
            tick();
        end

        // Requesters 0 and 2 reading distinct addresses must both win every cycle.
        for (int n = 0; n < 100; n++) begin
            drive(1'b0, 4'b0101, 4'b0000, 8'h20, 8'h00);
            @(negedge clk);
            model_check("fair");
            chk("fair ready", 32'(req_ready), 32'b0101);
            if (n > 0) chk("fair rsp_valid", 32'(rsp_valid), 32'b0101);
            tick();
        end

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 39) == 0, N'($urandom), N'($urandom),
                  (N*AW)'($urandom), (N*DW)'($urandom));
            @(negedge clk);
            model_check("rand");
            tick();
        end

        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        model_check("drain");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
